// File: rtl/alloc144_pkg.sv
// Shared types and constants for the 144-entry free-list allocator.
package alloc144_pkg;

  typedef logic [7:0] entry_id_t;

  localparam int        NENT     = 144;
  localparam entry_id_t NENT_ID  = 8'd144;
  localparam entry_id_t ENT_NONE = 8'd255;

  typedef enum logic {
    OS_EMPTY = 1'b0,
    OS_FULL  = 1'b1
  } os_state_t;

  // True when an id addresses a real pool entry.
  function automatic logic id_in_range(input entry_id_t id);
    return id < NENT_ID;
  endfunction

endpackage

// File: rtl/free_alloc144_flo144.sv
// flo144: 144-bit priority encoder returning the lowest-numbered set bit,
// or ENT_NONE (255) when no bit is set.
import alloc144_pkg::*;

module flo144 (
  input  logic [NENT-1:0] vec_i,
  output entry_id_t       idx_o
);

  // Scan from the top down so the last hit written is the lowest set bit.
  always_comb begin
    idx_o = ENT_NONE;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = entry_id_t'(i);
      end
    end
  end

endmodule

// File: rtl/free_alloc144.sv
// free_alloc144: free-list allocator for a 144-entry pool. One registered
// allocation port (valid/ready) always offering the lowest free entry, and
// two release ports per cycle with illegal-release detection.
// Optional low-water-mark output enabled by FREE_ALLOC144_LWM_EN.
import alloc144_pkg::*;

module free_alloc144 #(
  parameter int RSVD = 0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       alloc_vld,
  input  logic       alloc_rdy,
  output logic [7:0] alloc_id,
  input  logic       free0_v,
  input  logic [7:0] free0_id,
  input  logic       free1_v,
  input  logic [7:0] free1_id,
  output logic [7:0] free_cnt,
  output logic       err,
  output logic       empty
`ifdef FREE_ALLOC144_LWM_EN
  ,
  output logic [7:0] lwm
`endif
);

  localparam entry_id_t CNT_RST = entry_id_t'(NENT - RSVD);

  os_state_t       state_q, state_d;
  entry_id_t       id_q, id_d;
  logic [NENT-1:0] map_q, map_d;
  entry_id_t       cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [NENT-1:0] map_rst;
  entry_id_t       enc_id;
  logic            xfer, load;
  logic            held0, held1, ok0, ok1, bad_rel;

  // Reserved low entries start allocated; everything else starts free.
  for (genvar gi = 0; gi < NENT; gi++) begin : g_map_rst
    assign map_rst[gi] = (gi >= RSVD);
  end

  flo144 u_flo (
    .vec_i (map_q),
    .idx_o (enc_id)
  );

  // The entry sitting in the output register counts as held, not free, so
  // releasing it (even during its own transfer) is illegal. A second release
  // of the same id in the same cycle is a double free.
  assign xfer    = (state_q == OS_FULL) && alloc_rdy;
  assign load    = (state_q == OS_EMPTY) || xfer;
  assign held0   = (state_q == OS_FULL) && (free0_id == id_q);
  assign held1   = (state_q == OS_FULL) && (free1_id == id_q);
  assign ok0     = free0_v && id_in_range(free0_id) && !map_q[free0_id] && !held0;
  assign ok1     = free1_v && id_in_range(free1_id) && !map_q[free1_id] && !held1
                   && !(free0_v && (free0_id == free1_id));
  assign bad_rel = (free0_v && !ok0) || (free1_v && !ok1);

  // Next state: output-stage reload from the pre-edge map, releases, count, error.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    map_d   = map_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (load) begin
      if (enc_id != ENT_NONE) begin
        id_d          = enc_id;
        map_d[enc_id] = 1'b0;
        state_d       = OS_FULL;
      end else begin
        id_d    = ENT_NONE;
        state_d = OS_EMPTY;
      end
    end

    // A legal release never targets the encoder pick (its map bit is 0 here).
    if (ok0) begin
      map_d[free0_id] = 1'b1;
    end
    if (ok1) begin
      map_d[free1_id] = 1'b1;
    end

    cnt_d = cnt_q + {7'd0, ok0} + {7'd0, ok1} - {7'd0, xfer};

    if (bad_rel) begin
      err_d = 1'b1;
    end
  end

  // State registers with synchronous reset overriding any same-cycle activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OS_EMPTY;
      id_q    <= ENT_NONE;
      map_q   <= map_rst;
      cnt_q   <= CNT_RST;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      map_q   <= map_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef FREE_ALLOC144_LWM_EN
  entry_id_t lwm_q;

  // Track the minimum free count; follows one cycle behind free_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      lwm_q <= CNT_RST;
    end else if (cnt_q < lwm_q) begin
      lwm_q <= cnt_q;
    end
  end

  assign lwm = lwm_q;
`endif

  assign alloc_vld = (state_q == OS_FULL);
  assign alloc_id  = id_q;
  assign free_cnt  = cnt_q;
  assign err       = err_q;
  assign empty     = (cnt_q == 8'd0);

endmodule

// File: tb/tb_free_alloc144.sv
// Directed self-checking bench for free_alloc144 (RSVD=0).
module tb_free_alloc144;

  logic       clk;
  logic       rst;
  logic       alloc_vld;
  logic       alloc_rdy;
  logic [7:0] alloc_id;
  logic       free0_v;
  logic [7:0] free0_id;
  logic       free1_v;
  logic [7:0] free1_id;
  logic [7:0] free_cnt;
  logic       err;
  logic       empty;
`ifdef FREE_ALLOC144_LWM_EN
  logic [7:0] lwm;
`endif

  int total = 0;
  int bad   = 0;

  free_alloc144 #(.RSVD(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .alloc_vld (alloc_vld),
    .alloc_rdy (alloc_rdy),
    .alloc_id  (alloc_id),
    .free0_v   (free0_v),
    .free0_id  (free0_id),
    .free1_v   (free1_v),
    .free1_id  (free1_id),
    .free_cnt  (free_cnt),
    .err       (err),
    .empty     (empty)
`ifdef FREE_ALLOC144_LWM_EN
    ,
    .lwm       (lwm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rel(input logic v0, input logic [7:0] i0, input logic v1, input logic [7:0] i1);
    free0_v  = v0;
    free0_id = i0;
    free1_v  = v1;
    free1_id = i1;
    step();
    free0_v = 1'b0;
    free1_v = 1'b0;
    $display("release p0=%0b/%0d p1=%0b/%0d -> cnt=%0d err=%0b", v0, i0, v1, i1, free_cnt, err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; alloc_rdy = 1'b0;
    free0_v = 1'b0; free0_id = 8'd0; free1_v = 1'b0; free1_id = 8'd0;
    step(); step();
    chk("rst_vld", alloc_vld, 0);
    chk("rst_id", alloc_id, 255);
    chk("rst_cnt", free_cnt, 144);
    chk("rst_err", err, 0);
    chk("rst_empty", empty, 0);
`ifdef FREE_ALLOC144_LWM_EN
    chk("rst_lwm", lwm, 144);
`endif

    // Sweep: every entry granted once, ascending, one per cycle.
    rst = 1'b0; alloc_rdy = 1'b1;
    step();
    for (int i = 0; i < 144; i++) begin
      chk("sweep_vld", alloc_vld, 1);
      chk("sweep_id", alloc_id, i);
      chk("sweep_cnt", free_cnt, 144 - i);
      step();
    end
    $display("sweep done: vld=%0b id=%0d cnt=%0d", alloc_vld, alloc_id, free_cnt);
    chk("exh_vld", alloc_vld, 0);
    chk("exh_id", alloc_id, 255);
    chk("exh_cnt", free_cnt, 0);
    chk("exh_empty", empty, 1);

    // Release into an empty pool: grant appears two cycles later.
    rel(1'b1, 8'd37, 1'b0, 8'd0);
    chk("r37_cnt", free_cnt, 1);
    chk("r37_vld_t1", alloc_vld, 0);
    chk("r37_empty", empty, 0);
    step();
    chk("r37_vld_t2", alloc_vld, 1);
    chk("r37_id", alloc_id, 37);
    chk("r37_cnt_t2", free_cnt, 1);
    step();
    chk("r37_cnt_after", free_cnt, 0);
    chk("r37_vld_after", alloc_vld, 0);
    chk("r37_id_after", alloc_id, 255);

    // Hold id 5 while two releases land in the same cycle.
    alloc_rdy = 1'b0;
    rel(1'b1, 8'd5, 1'b0, 8'd0);
    step();
    chk("h5_id", alloc_id, 5);
    chk("h5_cnt", free_cnt, 1);
    rel(1'b1, 8'd90, 1'b1, 8'd12);
    chk("h5_id_held", alloc_id, 5);
    chk("h5_cnt2", free_cnt, 3);
    chk("h5_err", err, 0);
    alloc_rdy = 1'b1;
    step();
    chk("g12_id", alloc_id, 12);
    chk("g12_cnt", free_cnt, 2);
    step();
    chk("g90_id", alloc_id, 90);
    chk("g90_cnt", free_cnt, 1);
    step();
    chk("g_end_vld", alloc_vld, 0);
    chk("g_end_cnt", free_cnt, 0);

    // Releasing the held entry is illegal.
    alloc_rdy = 1'b0;
    rel(1'b1, 8'd7, 1'b0, 8'd0);
    step();
    chk("h7_id", alloc_id, 7);
    chk("h7_err0", err, 0);
    rel(1'b1, 8'd7, 1'b0, 8'd0);
    chk("h7_err", err, 1);
    chk("h7_cnt", free_cnt, 1);
    chk("h7_id_kept", alloc_id, 7);

    // Reset clears err; then out-of-range release.
    rst = 1'b1;
    step();
    chk("r2_err", err, 0);
    chk("r2_cnt", free_cnt, 144);
    chk("r2_vld", alloc_vld, 0);
    rst = 1'b0; alloc_rdy = 1'b1;
    step();
    chk("r2_id0", alloc_id, 0);
    step();
    chk("r2_id1", alloc_id, 1);
    chk("r2_cnt1", free_cnt, 143);
    alloc_rdy = 1'b0;
    rel(1'b0, 8'd0, 1'b1, 8'd200);
    chk("oor_err", err, 1);
    chk("oor_cnt", free_cnt, 143);
    chk("oor_id", alloc_id, 1);

    // Fresh run: double free of 20, then stream to 60 grants, then reset.
    rst = 1'b1;
    step();
    rst = 1'b0; alloc_rdy = 1'b1;
    step();
    for (int i = 0; i < 25; i++) begin
      chk("s_id", alloc_id, i);
      step();
    end
    chk("s_id25", alloc_id, 25);
    chk("s_cnt25", free_cnt, 119);
    alloc_rdy = 1'b0;
    rel(1'b1, 8'd20, 1'b1, 8'd20);
    chk("dbl_err", err, 1);
    chk("dbl_cnt", free_cnt, 120);
    chk("dbl_id", alloc_id, 25);
    alloc_rdy = 1'b1;
    step();
    chk("dbl_g20", alloc_id, 20);
    chk("dbl_cnt2", free_cnt, 119);
    for (int k = 1; k <= 35; k++) begin
      step();
      chk("s2_id", alloc_id, 25 + k);
      chk("s2_cnt", free_cnt, 119 - k);
    end
    alloc_rdy = 1'b0;
    step();
    $display("pre-reset: id=%0d cnt=%0d err=%0b", alloc_id, free_cnt, err);
    chk("pre_id", alloc_id, 60);
    chk("pre_cnt", free_cnt, 84);
    chk("err_sticky", err, 1);
`ifdef FREE_ALLOC144_LWM_EN
    chk("pre_lwm", lwm, 84);
`endif
    rst = 1'b1;
    step();
    chk("mid_vld", alloc_vld, 0);
    chk("mid_id", alloc_id, 255);
    chk("mid_cnt", free_cnt, 144);
    chk("mid_err", err, 0);
`ifdef FREE_ALLOC144_LWM_EN
    chk("mid_lwm", lwm, 144);
`endif
    rst = 1'b0; alloc_rdy = 1'b1;
    step();
    chk("post_vld", alloc_vld, 1);
    chk("post_id0", alloc_id, 0);
    step();
    chk("post_id1", alloc_id, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/free_alloc144.md
Name: free_alloc144

Overview:
- Free-list allocator for a 144-entry resource pool, such as rename tags or queue slots.
- Holds a 1-bit-per-entry free bitmap and always grants the lowest-numbered free entry, found with the 144-bit find-last-one priority encoder.
- Presents one registered allocation port with a valid/ready handshake, and accepts two release ports per cycle.
- Sits between the pool owner (releases) and the issue/rename stage (allocations).

Parameters:
- NENT, 144: pool size. Fixed at 144; any other value is a configuration error.
- RSVD, 0: entries [RSVD-1:0] are never free at reset and are never granted unless later released.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- alloc_vld  out  1  alloc_id holds a granted entry
- alloc_rdy  in  1  consumer takes alloc_id this cycle
- alloc_id  out  8  granted entry 0..143; 8'd255 when alloc_vld=0
- free0_v  in  1  release request, port 0
- free0_id  in  8  entry released on port 0
- free1_v  in  1  release request, port 1
- free1_id  in  8  entry released on port 1
- free_cnt  out  8  number of unallocated entries, including the one held in alloc_id
- err  out  1  sticky: illegal release seen
- empty  out  1  free_cnt==0

Behaviour:
- Reset (rst=1 at a clock edge):
  - map[i] = (i>=RSVD); out register empty.
  - alloc_vld=0, alloc_id=255, free_cnt=144-RSVD, err=0.
  - The map and all outputs go to these values whenever rst=1 at an edge, mid-operation included; no transfer or release in that cycle takes effect.
- Output stage state machine, states OS_EMPTY and OS_FULL:
  - In OS_EMPTY, or in OS_FULL with alloc_vld & alloc_rdy, the stage loads from the encoder:
    - encoder result != 255: load alloc_id from the encoder result, clear that map bit at the same edge, and go (or stay) OS_FULL;
    - encoder result == 255: go to OS_EMPTY.
  - In OS_FULL without alloc_rdy: hold alloc_id; map unchanged by the allocation side.
- Encoder input: registered map only. A release made in cycle t is visible to the encoder in cycle t+1.
- Latency:
  - First grant: the first cycle after rst deasserts shows alloc_vld=1, alloc_id=RSVD.
  - Back-to-back: with alloc_rdy held high, one grant per cycle, ascending order.
  - Release to grant: a release into an empty pool in cycle t gives alloc_vld=1 in cycle t+2.
- Releases:
  - A legal release sets map[id] at the clock edge.
  - Legal means: id<144, map[id]==0, and id is not the entry currently held in alloc_id while OS_FULL.
  - An illegal release is ignored and sets err. err clears only on rst.
  - Both ports valid with the same id: the first is accepted, the second is treated as an illegal double-free (err=1).
  - A release of the id being transferred in the same cycle is illegal: that entry is held, not free.
- free_cnt:
  - next = free_cnt + (legal releases, 0..2) − (1 if alloc_vld & alloc_rdy).
  - Never exceeds 144 and never wraps below 0 given legal use.
- Simultaneous events: a transfer and two releases in one cycle are all applied. The reload uses the pre-edge map, so same-cycle releases become eligible next cycle.
- Pool empty with OS_EMPTY: alloc_vld=0, alloc_id=255, empty=1.

Optional Feature:
- Macro FREE_ALLOC144_LWM_EN.
- Defined:
  - adds output lwm[7:0], the low-water mark, i.e. the minimum free_cnt seen since reset;
  - reset value 144-RSVD;
  - updates the cycle after free_cnt falls below it.
- Undefined: port and register are absent; the rest of the behaviour is identical.

Decomposition:
- Package alloc144_pkg:
  - typedef entry_id_t = logic [7:0];
  - constants NENT=144 and ENT_NONE=8'd255;
  - enum os_state_t {OS_EMPTY, OS_FULL}.
- Sub-module: instantiate the existing flo144 encoder on the map. No other sub-modules.

Test Plan:
- Reset with RSVD=0, alloc_rdy=1 for 145 cycles → ids 0,1,…,143 in consecutive cycles, then alloc_vld=0, alloc_id=255, free_cnt=0, empty=1.
- Pool exhausted, free0 id=37 in cycle t → alloc_vld=1 with alloc_id=37 in cycle t+2; free_cnt goes 0→1, then →0 after the transfer.
- alloc_rdy=0 holding id 5, free0=90 and free1=12 in the same cycle → alloc_id stays 5, free_cnt increases by 2, err=0; next grants are 12 then 90.
- free0_id=free1_id=20 (20 allocated) → map[20]=1, free_cnt+1, err=1; err stays 1 until rst.
- Release of the held alloc_id, or of id=200 → ignored, err=1, free_cnt unchanged.
- rst asserted mid-stream after 60 grants → next cycle alloc_vld=0, free_cnt=144; then grants restart at id 0. With the LWM macro defined: lwm=84 before the reset, 144 after it.
